// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int IF_XLEN = 32;
  localparam logic [IF_XLEN-1:0] IF_NOP = 32'h0000_0000;
  localparam int PC_INC = 4;

  // Queue entry at the pipeline's native word width; narrower or wider builds
  // keep the same {instr, postPc} layout inside the stage.
  typedef struct packed {
    logic [IF_XLEN-1:0] instr;
    logic [IF_XLEN-1:0] postPc;
  } ifEntryT;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Generic synchronous FIFO with a synchronous clear; DEPTH must be a power of 2
// so the pointers wrap naturally.
module if_prefetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop & !empty;
  // A pop frees the slot the push lands in, so push-while-full is legal then.
  assign doPush  = push & (!full | doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage: PC generator with valid/ready fetch requests, in-order
// responses, a prefetch queue towards ID and redirect with in-flight discard.
module stage_if_prefetch
  import if_pkg::*;
#(
  parameter int              XLEN     = IF_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(IF_NOP)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_post_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] postPc;
  } entryT;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pcNext;
  logic [CNT_W-1:0] dropCnt;
  logic [CNT_W-1:0] dropCntNext;
  logic [CNT_W-1:0] inFlight;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credit;
  logic             redirect;
  logic             reqFire;
  logic             rspAccept;
  logic             qPush;
  logic             qPop;
  logic             qFull;
  logic             qEmpty;
  logic             shFull;
  logic             shEmpty;
  logic [XLEN-1:0]  shHead;
  entryT            qPushData;
  entryT            qHead;

  // Queued plus outstanding never exceeds DEPTH, so a response always finds room.
  assign redirect       = branch_taken | jump | flush;
  assign credit         = {1'b0, occupancy} + {1'b0, inFlight};
  assign imem_req_valid = !reset && pc_write && !redirect && (credit < CREDIT_MAX);
  assign imem_req_addr  = pc;
  assign reqFire        = imem_req_valid & imem_req_ready;
  assign rspAccept      = imem_rsp_valid & !shEmpty;
  assign qPush          = rspAccept & (dropCnt == '0) & !redirect;
  assign qPop           = id_valid & id_ready;
  assign qPushData      = '{instr: imem_rsp_data, postPc: shHead + XLEN'(PC_INC)};

  assign id_valid       = !qEmpty;
  assign id_instruction = qEmpty ? NOP : qHead.instr;
  assign id_post_pc     = qEmpty ? '0  : qHead.postPc;

  // On redirect every outstanding fetch becomes stale; the one returning this
  // cycle is consumed right now, the rest are counted down in dropCnt.
  always_comb begin
    pcNext      = pc;
    dropCntNext = dropCnt;
    if (redirect) begin
      if (branch_taken)  pcNext = branch_target;
      else if (jump)     pcNext = jump_target;
      dropCntNext = inFlight - CNT_W'(rspAccept);
    end else begin
      if (reqFire) pcNext = pc + XLEN'(PC_INC);
      if (rspAccept && (dropCnt != '0)) dropCntNext = dropCnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      dropCnt <= '0;
    end else begin
      pc      <= pcNext;
      dropCnt <= dropCntNext;
    end
  end

  if_prefetch_fifo #(
    .WIDTH ($bits(entryT)),
    .DEPTH (DEPTH)
  ) instrQueue (
    .clk      (clk),
    .reset    (reset),
    .push     (qPush),
    .pushData (qPushData),
    .pop      (qPop),
    .clear    (redirect),
    .popData  (qHead),
    .full     (qFull),
    .empty    (qEmpty),
    .count    (occupancy)
  );

  // Issued addresses, popped by every response (kept or dropped); its count is
  // the in-flight fetch count.
  if_prefetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) pcShadow (
    .clk      (clk),
    .reset    (reset),
    .push     (reqFire),
    .pushData (pc),
    .pop      (rspAccept),
    .clear    (1'b0),
    .popData  (shHead),
    .full     (shFull),
    .empty    (shEmpty),
    .count    (inFlight)
  );

  queueNoOverflow: assert property (@(posedge clk) disable iff (reset)
    !(qFull && qPush && !qPop));
  shadowNoOverflow: assert property (@(posedge clk) disable iff (reset)
    !(shFull && reqFire && !rspAccept));

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed and randomized bench for stage_if_prefetch with an in-order memory
// model and a program-order reference for requests and deliveries.
module tb_stage_if_prefetch;
  import if_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instruction;
  logic [31:0] id_post_pc;

  always #5 clk = ~clk;

  stage_if_prefetch #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP      (IF_NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_write       (pc_write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_post_pc     (id_post_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pendT;

  pendT        pending[$];
  int unsigned cycleCnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] mPc = RESET_PC;
  logic [31:0] ePc = RESET_PC;
  int          memLat = 1;
  bit          memLatRand = 1'b0;
  int          reqSeen = 0;
  int          delivSeen = 0;
  bit          prevHold = 1'b0;
  logic [31:0] prevInstr = '0;
  logic [31:0] prevPost = '0;

  function automatic logic [31:0] memFunc(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present the oldest outstanding response once its latency has elapsed.
  task automatic prepMemory();
    if (pending.size() > 0 && pending[0].due <= cycleCnt) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memFunc(pending[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // One clock: check against the reference, cross the edge, advance the model.
  task automatic applyStimulus();
    bit          reqFire;
    bit          rspFire;
    bit          pop;
    bit          redir;
    logic [31:0] reqAddr;
    int          lat;
    ifEntryT     expE;
    ifEntryT     gotE;
    #1;
    reqFire = (imem_req_valid === 1'b1) && imem_req_ready;
    rspFire = imem_rsp_valid;
    pop     = (id_valid === 1'b1) && id_ready;
    redir   = branch_taken | jump | flush;
    reqAddr = imem_req_addr;
    if (!reset) begin
      checkOutput("reqAddr", imem_req_addr, mPc);
      if (redir || !pc_write) checkOutput("reqBlocked", 32'(imem_req_valid), 32'd0);
      if (id_valid !== 1'b1) begin
        checkOutput("idNopInstr", id_instruction, IF_NOP);
        checkOutput("idNopPc", id_post_pc, 32'd0);
      end
      if (prevHold) begin
        checkOutput("holdValid", 32'(id_valid), 32'd1);
        checkOutput("holdInstr", id_instruction, prevInstr);
        checkOutput("holdPc", id_post_pc, prevPost);
      end
      if (pop) begin
        expE = '{instr: memFunc(ePc), postPc: ePc + 32'd4};
        gotE = '{instr: id_instruction, postPc: id_post_pc};
        checkOutput("delivInstr", gotE.instr, expE.instr);
        checkOutput("delivPc", gotE.postPc, expE.postPc);
        ePc = ePc + 32'd4;
        delivSeen++;
      end
      checkOutput("outstandingBound", 32'(pending.size() > DEPTH), 32'd0);
    end
    prevHold  = !reset && (id_valid === 1'b1) && !id_ready && !redir;
    prevInstr = id_instruction;
    prevPost  = id_post_pc;
    @(posedge clk);
    cycleCnt++;
    if (!reset) begin
      if (rspFire) void'(pending.pop_front());
      if (reqFire) begin
        lat = memLatRand ? int'($urandom_range(1, 4)) : memLat;
        pending.push_back('{addr: reqAddr, due: cycleCnt - 1 + lat});
        mPc = mPc + 32'd4;
        reqSeen++;
      end
      if (redir) begin
        if (branch_taken)  mPc = branch_target;
        else if (jump)     mPc = jump_target;
        ePc = mPc;
      end
    end
    @(negedge clk);
    prepMemory();
  endtask

  task automatic doReset();
    reset = 1'b1;
    pc_write = 1'b1; branch_taken = 1'b0; jump = 1'b0; flush = 1'b0;
    branch_target = '0; jump_target = '0; id_ready = 1'b1; imem_req_ready = 1'b1;
    pending.delete();
    mPc = RESET_PC; ePc = RESET_PC; prevHold = 1'b0;
    repeat (2) @(negedge clk);
    prepMemory();
    #1;
    checkOutput("rstReqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("rstReqAddr", imem_req_addr, RESET_PC);
    checkOutput("rstIdValid", 32'(id_valid), 32'd0);
    checkOutput("rstIdInstr", id_instruction, IF_NOP);
    checkOutput("rstIdPc", id_post_pc, 32'd0);
    reset = 1'b0;
  endtask

  task automatic waitIdValid(input int maxCycles);
    for (int i = 0; i < maxCycles && id_valid !== 1'b1; i++) applyStimulus();
    #1;
    checkOutput("idValidTimeout", 32'(id_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] savedPc;
    int          r;

    // Streaming with a 1-cycle memory
    memLat = 1; memLatRand = 1'b0;
    doReset();
    #1 checkOutput("firstReqValid", 32'(imem_req_valid), 32'd1);
    applyStimulus();
    for (int k = 3; k <= 12; k++) begin
      applyStimulus();
      #1;
      checkOutput("streamValid", 32'(id_valid), 32'd1);
      checkOutput("streamPc", id_post_pc, 32'(4 * (k - 2)));
    end

    // ID stalled: queue fills to DEPTH then issue stops
    doReset();
    id_ready = 1'b0;
    reqSeen = 0;
    repeat (10) applyStimulus();
    #1;
    checkOutput("holdReqCount", 32'(reqSeen), 32'd4);
    checkOutput("holdReqStall", 32'(imem_req_valid), 32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput("drainPc", id_post_pc, 32'(4 * (i + 1)));
      applyStimulus();
    end

    // Branch with two fetches in flight on a 3-cycle memory
    memLat = 3;
    doReset();
    applyStimulus();
    applyStimulus();
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    applyStimulus();
    branch_taken = 1'b0;
    #1;
    checkOutput("brReqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("brReqAddr", imem_req_addr, 32'h0000_0100);
    waitIdValid(20);
    checkOutput("brFirstPc", id_post_pc, 32'h0000_0104);
    checkOutput("brFirstInstr", id_instruction, memFunc(32'h0000_0100));

    // Branch beats jump
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    jump = 1'b1; jump_target = 32'h0000_0300;
    applyStimulus();
    branch_taken = 1'b0; jump = 1'b0;
    #1 checkOutput("bjAddr", imem_req_addr, 32'h0000_0200);

    // Flush coinciding with a response
    memLat = 1;
    for (int i = 0; i < 10 && imem_rsp_valid !== 1'b1; i++) applyStimulus();
    checkOutput("flushRspSeen", 32'(imem_rsp_valid), 32'd1);
    flush = 1'b1;
    savedPc = mPc;
    applyStimulus();
    flush = 1'b0;
    #1;
    checkOutput("flushPcKept", imem_req_addr, savedPc);
    checkOutput("flushQueueEmpty", 32'(id_valid), 32'd0);
    waitIdValid(20);
    checkOutput("flushFirstPc", id_post_pc, savedPc + 32'd4);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    applyStimulus();
    branch_taken = 1'b0;
    #1;
    checkOutput("wrapReqAddr", imem_req_addr, 32'hFFFF_FFFC);
    checkOutput("wrapReqValid", 32'(imem_req_valid), 32'd1);
    applyStimulus();
    #1 checkOutput("wrapNextAddr", imem_req_addr, 32'h0000_0000);
    waitIdValid(20);
    checkOutput("wrapPostPc", id_post_pc, 32'h0000_0000);
    checkOutput("wrapInstr", id_instruction, memFunc(32'hFFFF_FFFC));

    // Asynchronous reset with fetches in flight
    memLat = 3;
    for (int i = 0; i < 30 && !(pending.size() >= 2 && id_valid === 1'b1); i++) applyStimulus();
    checkOutput("midRstInFlight", 32'(pending.size() >= 2), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midRstReqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("midRstReqAddr", imem_req_addr, RESET_PC);
    checkOutput("midRstIdValid", 32'(id_valid), 32'd0);
    checkOutput("midRstIdInstr", id_instruction, IF_NOP);
    checkOutput("midRstIdPc", id_post_pc, 32'd0);

    // Randomized traffic against the reference
    memLatRand = 1'b1;
    doReset();
    delivSeen = 0;
    for (int c = 0; c < 800; c++) begin
      pc_write       = ($urandom_range(0, 9) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 8);
      r = int'($urandom_range(0, 39));
      branch_taken   = (r == 0) || (r == 3);
      jump           = (r == 1) || (r == 3);
      flush          = (r == 2);
      branch_target  = $urandom & 32'hFFFF_FFFC;
      jump_target    = $urandom & 32'hFFFF_FFFC;
      applyStimulus();
    end
    checkOutput("randomDeliveries", 32'(delivSeen >= 80), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
